// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry, colour constants and the ball FSM encoding.
package vga_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK = 12'h000;
  localparam rgb_t COL_WHITE = 12'hFFF;
  localparam rgb_t COL_HIT   = 12'hF00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_FLASH = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ball_renderer_axis_bounce.sv
// One axis of ball motion: position/direction register with edge clamp and bounce flag.
module axis_bounce #(
  parameter int LIMIT = 640,
  parameter int SIZE  = 16,
  parameter int SPEED = 2,
  parameter int INIT  = 312
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_step,
  output logic [9:0] o_pos,
  output logic       o_bounce
);

  logic [9:0]  r_pos;
  logic        r_dir;
  logic [10:0] w_pos_ext;
  logic [10:0] w_far_edge;
  logic [9:0]  w_next_pos;
  logic        w_next_dir;
  logic        w_hit;

  // Widened to 11 bits so the far-edge sum never wraps near the limit.
  assign w_pos_ext  = {1'b0, r_pos};
  assign w_far_edge = w_pos_ext + 11'(SIZE) + 11'(SPEED);

  always_comb begin
    w_next_pos = r_pos;
    w_next_dir = r_dir;
    w_hit      = 1'b0;
    if (r_dir) begin
      if (w_far_edge > 11'(LIMIT)) begin
        w_next_pos = 10'(LIMIT - SIZE);
        w_next_dir = 1'b0;
        w_hit      = 1'b1;
      end else begin
        w_next_pos = r_pos + 10'(SPEED);
      end
    end else begin
      if (w_pos_ext < 11'(SPEED)) begin
        w_next_pos = '0;
        w_next_dir = 1'b1;
        w_hit      = 1'b1;
      end else begin
        w_next_pos = r_pos - 10'(SPEED);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pos <= 10'(INIT);
      r_dir <= 1'b1;
    end else if (i_step) begin
      r_pos <= w_next_pos;
      r_dir <= w_next_dir;
    end
  end

  assign o_pos    = r_pos;
  assign o_bounce = i_step & w_hit;

endmodule

// File: rtl/ball_renderer.sv
// Square bouncing ball: run/pause/flash control, per-frame motion and a one-strobe
// registered pixel stage that keeps RGB aligned with the delayed syncs.
module ball_renderer import vga_pkg::*; #(
  parameter int H_RES        = vga_pkg::H_RES,
  parameter int V_RES        = vga_pkg::V_RES,
  parameter int BALL_SIZE    = 16,
  parameter int SPEED        = 2,
  parameter int X_INIT       = 312,
  parameter int Y_INIT       = 232,
  parameter int FLASH_FRAMES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pix_stb,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_active,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic       i_animate,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [3:0] o_r,
  output logic [3:0] o_g,
  output logic [3:0] o_b,
  output logic       o_hs,
  output logic       o_vs,
  output logic [7:0] o_bounce_cnt,
  output logic       o_running
);

  localparam int FCW = $clog2(FLASH_FRAMES + 1);

  logic [1:0]     r_state;
  logic [FCW-1:0] r_flash_cnt;
  logic [7:0]     r_bounce_cnt;
  logic           r_pause_d;
  rgb_t           r_rgb;
  logic           r_hs;
  logic           r_vs;

  logic       w_frame_tick;
  logic       w_pause_rise;
  logic       w_moving;
  logic       w_move;
  logic       w_bounce_x;
  logic       w_bounce_y;
  logic       w_bounce;
  logic [9:0] w_ball_x;
  logic [9:0] w_ball_y;
  logic       w_inside;
  rgb_t       w_colour;

  assign w_frame_tick = i_animate & i_pix_stb;
  assign w_pause_rise = i_pause & ~r_pause_d;
  assign w_moving     = (r_state == ST_RUN) | (r_state == ST_FLASH);
  // A pause edge wins over a coincident tick, so that tick produces no motion.
  assign w_move       = w_frame_tick & w_moving & ~w_pause_rise;
  assign w_bounce     = w_bounce_x | w_bounce_y;

  axis_bounce #(
    .LIMIT (H_RES),
    .SIZE  (BALL_SIZE),
    .SPEED (SPEED),
    .INIT  (X_INIT)
  ) u_axis_x (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_step   (w_move),
    .o_pos    (w_ball_x),
    .o_bounce (w_bounce_x)
  );

  axis_bounce #(
    .LIMIT (V_RES),
    .SIZE  (BALL_SIZE),
    .SPEED (SPEED),
    .INIT  (Y_INIT)
  ) u_axis_y (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_step   (w_move),
    .o_pos    (w_ball_y),
    .o_bounce (w_bounce_y)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_flash_cnt  <= '0;
      r_bounce_cnt <= '0;
      r_pause_d    <= 1'b0;
    end else begin
      r_pause_d <= i_pause;
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_RUN;
        end
        ST_RUN, ST_FLASH: begin
          if (w_pause_rise) begin
            r_state <= ST_PAUSE;
          end else if (w_move) begin
            if (w_bounce) begin
              r_state      <= ST_FLASH;
              r_flash_cnt  <= FCW'(FLASH_FRAMES);
              r_bounce_cnt <= sat_inc8(r_bounce_cnt);
            end else if (r_state == ST_FLASH) begin
              r_flash_cnt <= r_flash_cnt - FCW'(1);
              if (r_flash_cnt == FCW'(1)) r_state <= ST_RUN;
            end
          end
        end
        ST_PAUSE: begin
          if (w_pause_rise) begin
            r_state     <= ST_RUN;
            r_flash_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_inside = i_active
                  & ({1'b0, i_x} >= {1'b0, w_ball_x})
                  & ({1'b0, i_x} <  {1'b0, w_ball_x} + 11'(BALL_SIZE))
                  & ({2'b0, i_y} >= {1'b0, w_ball_y})
                  & ({2'b0, i_y} <  {1'b0, w_ball_y} + 11'(BALL_SIZE));

  always_comb begin
    w_colour = COL_BLACK;
    if (w_inside) w_colour = (r_state == ST_FLASH) ? COL_HIT : COL_WHITE;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rgb <= COL_BLACK;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (i_pix_stb) begin
      r_rgb <= w_colour;
      r_hs  <= i_hs;
      r_vs  <= i_vs;
    end
  end

  assign o_r          = r_rgb.r;
  assign o_g          = r_rgb.g;
  assign o_b          = r_rgb.b;
  assign o_hs         = r_hs;
  assign o_vs         = r_vs;
  assign o_bounce_cnt = r_bounce_cnt;
  assign o_running    = w_moving;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer with a frame-level behavioural model checked every cycle.
module tb_ball_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic       anim = 1'b0;
  logic [9:0] px = '0;
  logic [8:0] py = '0;
  logic       active = 1'b0;
  logic       hs = 1'b1;
  logic       vs = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] o_r, o_g, o_b;
  logic       o_hs, o_vs, o_running;
  logic [7:0] o_bounce_cnt;

  int nChecks = 0;
  int nPass = 0;
  bit cmpOn = 1'b0;

  typedef enum int {M_IDLE, M_RUN, M_FLASH, M_PAUSE} mode_e;
  mode_e       mMode = M_IDLE;
  int          mX = 312, mY = 232, mVx = 1, mVy = 1;
  int          mFlash = 0, mBounces = 0;
  bit          mPausePrev = 1'b0;
  logic [11:0] mRgb = 12'h000;
  bit          mHs = 1'b1, mVs = 1'b1;

  always #5 clk = ~clk;

  ball_renderer dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_pix_stb    (stb),
    .i_x          (px),
    .i_y          (py),
    .i_active     (active),
    .i_hs         (hs),
    .i_vs         (vs),
    .i_animate    (anim),
    .i_start      (start),
    .i_pause      (pause),
    .o_r          (o_r),
    .o_g          (o_g),
    .o_b          (o_b),
    .o_hs         (o_hs),
    .o_vs         (o_vs),
    .o_bounce_cnt (o_bounce_cnt),
    .o_running    (o_running)
  );

  task automatic checkOutput(input string name, input logic [11:0] got, input logic [11:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
  endtask

  // One axis moved by 2 px as free arithmetic, then folded back onto the screen.
  function automatic bit moveAxis(input int p, input int v, input int lim, output int np, output int nv);
    int t;
    t  = p + 2 * v;
    np = t;
    nv = v;
    if (t < 0) begin
      np = 0;
      nv = 1;
      return 1'b1;
    end
    if (t + 16 > lim) begin
      np = lim - 16;
      nv = -1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mX = 312; mY = 232; mVx = 1; mVy = 1;
    mFlash = 0; mBounces = 0; mPausePrev = 1'b0;
    mRgb = 12'h000; mHs = 1'b1; mVs = 1'b1;
  endtask

  task automatic modelStep();
    bit rise, tick, hitX, hitY, in;
    int nx, nvx, ny, nvy;
    if (stb) begin
      in = active && int'(px) >= mX && int'(px) < mX + 16 && int'(py) >= mY && int'(py) < mY + 16;
      mRgb = in ? ((mMode == M_FLASH) ? 12'hF00 : 12'hFFF) : 12'h000;
      mHs = hs;
      mVs = vs;
    end
    rise = pause && !mPausePrev;
    mPausePrev = pause;
    tick = stb && anim;
    if (mMode == M_IDLE) begin
      if (start) mMode = M_RUN;
    end else if (mMode == M_PAUSE) begin
      if (rise) begin mMode = M_RUN; mFlash = 0; end
    end else if (rise) begin
      mMode = M_PAUSE;
    end else if (tick) begin
      hitX = moveAxis(mX, mVx, 640, nx, nvx);
      hitY = moveAxis(mY, mVy, 480, ny, nvy);
      mX = nx; mVx = nvx; mY = ny; mVy = nvy;
      if (hitX || hitY) begin
        mBounces = (mBounces < 255) ? mBounces + 1 : 255;
        mMode = M_FLASH;
        mFlash = 8;
      end else if (mMode == M_FLASH) begin
        mFlash--;
        if (mFlash == 0) mMode = M_RUN;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmpOn) begin
        checkOutput("cyc_rgb", {o_r, o_g, o_b}, mRgb);
        checkOutput("cyc_hs", 12'(o_hs), 12'(mHs));
        checkOutput("cyc_vs", 12'(o_vs), 12'(mVs));
        checkOutput("cyc_bounce_cnt", 12'(o_bounce_cnt), 12'(mBounces));
        checkOutput("cyc_running", 12'(o_running), 12'((mMode == M_RUN) || (mMode == M_FLASH)));
      end
    end
  end

  task automatic applyStimulus(input bit s, input bit a, input int x, input int y,
                               input bit act, input bit h, input bit v);
    @(posedge clk);
    #1;
    stb = s; anim = a; px = 10'(x); py = 9'(y); active = act; hs = h; vs = v;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic tick();
    applyStimulus(1, 1, 0, 0, 0, 1, 1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
    idle();
  endtask

  // Strobe every 4 clocks with animate held across 4 clocks; only one strobe overlaps.
  task automatic slowFrame();
    for (int c = 0; c < 8; c++) applyStimulus(c % 4 == 0, c >= 2 && c < 6, 0, 0, 0, 1, 1);
  endtask

  task automatic probe(input string name, input int x, input int y, input bit act,
                       input bit h, input logic [11:0] want);
    applyStimulus(1, 0, x, y, act, h, 1);
    applyStimulus(0, 0, x, y, 0, 1, 1);
    checkOutput(name, {o_r, o_g, o_b}, want);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rgb"}, {o_r, o_g, o_b}, 12'h000);
    checkOutput({tag, "_hs"}, 12'(o_hs), 12'h1);
    checkOutput({tag, "_vs"}, 12'(o_vs), 12'h1);
    checkOutput({tag, "_running"}, 12'(o_running), 12'h0);
    checkOutput({tag, "_bounce_cnt"}, 12'(o_bounce_cnt), 12'h0);
  endtask

  task automatic pulseStart();
    idle();
    start = 1'b1;
    idle();
    start = 1'b0;
  endtask

  initial begin
    repeat (3) idle();
    checkResetOutputs("por");
    rst_n = 1'b1;
    cmpOn = 1'b1;

    // IDLE: static ball at (312,232); sync delayed alongside colour.
    probe("idle_in", 312, 232, 1, 0, 12'hFFF);
    checkOutput("idle_hs_aligned", 12'(o_hs), 12'h0);
    probe("idle_inactive", 312, 232, 0, 1, 12'h000);
    checkOutput("idle_hs_back", 12'(o_hs), 12'h1);

    pulseStart();
    checkOutput("start_running", 12'(o_running), 12'h1);
    repeat (3) slowFrame();
    idle();
    probe("f3_corner_tl", 318, 238, 1, 1, 12'hFFF);
    probe("f3_left_out", 317, 238, 1, 1, 12'h000);
    probe("f3_corner_br", 333, 253, 1, 1, 12'hFFF);
    probe("f3_right_out", 334, 253, 1, 1, 12'h000);
    probe("f3_below_out", 318, 254, 1, 1, 12'h000);

    // Tick 117 bounces off the bottom; by tick 156 x has landed exactly on 624.
    ticks(153);
    checkOutput("t156_cnt", 12'(o_bounce_cnt), 12'd1);
    probe("t156_edge", 624, 386, 1, 1, 12'hFFF);
    probe("t156_edge_out", 623, 386, 1, 1, 12'h000);
    probe("t156_far", 639, 401, 1, 1, 12'hFFF);

    ticks(1);
    checkOutput("t157_cnt", 12'(o_bounce_cnt), 12'd2);
    probe("t157_hit", 624, 384, 1, 1, 12'hF00);
    probe("t157_above", 624, 383, 1, 1, 12'h000);
    ticks(7);
    probe("t164_still_hit", 610, 370, 1, 1, 12'hF00);
    ticks(1);
    probe("t165_run", 608, 368, 1, 1, 12'hFFF);

    // Pause edge coincident with a frame tick: freeze without moving.
    tick();
    pause = 1'b1;
    idle();
    checkOutput("pause_running", 12'(o_running), 12'h0);
    probe("pause_frozen", 608, 368, 1, 1, 12'hFFF);
    probe("pause_not_moved", 606, 366, 1, 1, 12'h000);
    ticks(2);
    probe("pause_frozen2", 608, 368, 1, 1, 12'hFFF);
    probe("pause_not_moved2", 606, 366, 1, 1, 12'h000);
    idle();
    pause = 1'b0;
    idle();
    pause = 1'b1;
    idle();
    checkOutput("resume_running", 12'(o_running), 12'h1);
    ticks(1);
    probe("resume_moved", 606, 366, 1, 1, 12'hFFF);
    probe("resume_right_out", 622, 368, 1, 1, 12'h000);
    pause = 1'b0;

    // Asynchronous reset while outputs are live.
    probe("pre_reset_in", 606, 366, 1, 0, 12'hFFF);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) idle();
    rst_n = 1'b1;
    probe("rst_home", 312, 232, 1, 1, 12'hFFF);
    probe("rst_home_out", 311, 232, 1, 1, 12'h000);
    probe("rst_home_br", 327, 247, 1, 1, 12'hFFF);

    // x bounces every 313 ticks from 157, y every 233 from 117; first coincidence is tick 36465.
    pulseStart();
    for (int k = 1; k <= 36465; k++)
      applyStimulus(1, 1, (k * 7) % 640, (k * 13) % 480, 1, k % 5 != 0, k % 11 != 0);
    idle();
    checkOutput("corner_cnt_sat", 12'(o_bounce_cnt), 12'd255);
    probe("corner_pos", 624, 464, 1, 1, 12'hF00);
    probe("corner_left_out", 623, 464, 1, 1, 12'h000);
    probe("corner_far", 639, 479, 1, 1, 12'hF00);
    ticks(1);
    probe("corner_after", 622, 462, 1, 1, 12'hF00);
    probe("corner_after_out", 638, 462, 1, 1, 12'h000);
    checkOutput("corner_cnt_hold", 12'(o_bounce_cnt), 12'd255);

    repeat (2) idle();
    cmpOn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
